// File: rtl/register_file.sv
// Architectural register file with per-register ROB rename tags.
// Reads are combinational and include a same-cycle commit bypass.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [4:0]  rs1_from_dispatcher,
    input  logic [4:0]  rs2_from_dispatcher,
    output logic [31:0] V1_to_dispatcher,
    output logic [31:0] V2_to_dispatcher,
    output logic [4:0]  Q1_to_dispatcher,
    output logic [4:0]  Q2_to_dispatcher,
    input  logic        rename_signal_from_dispatcher,
    input  logic [4:0]  rd_from_dispatcher,
    input  logic [4:0]  rob_id_from_dispatcher,
    input  logic        commit_flag_from_rob,
    input  logic [4:0]  rd_from_rob,
    input  logic [4:0]  Q_from_rob,
    input  logic [31:0] V_from_rob,
    input  logic        misbranch_flag_from_rob
);

    logic [31:0] value [32];
    logic [4:0]  tag   [32];

    logic commit_en;
    logic rename_en;

    assign commit_en = rdy && commit_flag_from_rob && (rd_from_rob != 5'd0);
    assign rename_en = rdy && rename_signal_from_dispatcher &&
                       (rd_from_dispatcher != 5'd0) && !misbranch_flag_from_rob;

    // Entry 0 is never written, so x0 stays zero after reset; reads of x0 are forced to zero anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                value[i] <= '0;
                tag[i]   <= '0;
            end
        end else if (rdy) begin
            if (commit_en) begin
                value[rd_from_rob] <= V_from_rob;
                if (tag[rd_from_rob] == Q_from_rob)
                    tag[rd_from_rob] <= '0;
            end
            if (misbranch_flag_from_rob) begin
                for (int unsigned i = 0; i < 32; i++)
                    tag[i] <= '0;
            end else if (rename_en) begin
                tag[rd_from_dispatcher] <= rob_id_from_dispatcher;
            end
        end
    end

    // Bypass only when the retiring instruction is still the register's recorded producer.
    function automatic logic bypass_hit(input logic [4:0] rs, input logic [4:0] cur_tag);
        return commit_flag_from_rob && (rd_from_rob == rs) &&
               (cur_tag == Q_from_rob) && (Q_from_rob != 5'd0);
    endfunction

    always_comb begin
        V1_to_dispatcher = '0;
        Q1_to_dispatcher = '0;
        if (rs1_from_dispatcher != 5'd0) begin
            if (bypass_hit(rs1_from_dispatcher, tag[rs1_from_dispatcher])) begin
                V1_to_dispatcher = V_from_rob;
            end else begin
                V1_to_dispatcher = value[rs1_from_dispatcher];
                Q1_to_dispatcher = tag[rs1_from_dispatcher];
            end
        end
    end

    always_comb begin
        V2_to_dispatcher = '0;
        Q2_to_dispatcher = '0;
        if (rs2_from_dispatcher != 5'd0) begin
            if (bypass_hit(rs2_from_dispatcher, tag[rs2_from_dispatcher])) begin
                V2_to_dispatcher = V_from_rob;
            end else begin
                V2_to_dispatcher = value[rs2_from_dispatcher];
                Q2_to_dispatcher = tag[rs2_from_dispatcher];
            end
        end
    end

endmodule
